spi_display_host: RTL and testbench
===================================

Name: spi_display_host

Overview:
- SPI host that drives an ILI9340-style display link, for bench-driving and for chaining FPGA boards to SPI displays.
- Accepts a pixel window and a stream of RGB565 pixels.
- Emits the command sequence over a 4-wire write-only SPI bus (clk, cs, data, dc): column address 0x2A, row address 0x2B, memory write 0x2C, then pixel data.
- Owns the transaction framing and the SPI clock generation.

Parameters:
- WIDTH, 16, width of the coordinate fields. Coordinates are sent as 2 bytes, MSB first; bits above 15 are ignored.
- CLK_DIV, 4, number of clk cycles per spi_clk half-period. Must be at least 1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous reset, active-low
- win_x_start  input  WIDTH  first column of the window
- win_y_start  input  WIDTH  first row of the window
- win_x_end  input  WIDTH  last column, inclusive
- win_y_end  input  WIDTH  last row, inclusive
- win_valid  input  1  window request
- win_ready  output  1  high only in IDLE
- pixel_data  input  16  RGB565 pixel, sent high byte first
- pixel_valid  input  1  pixel available
- pixel_ready  output  1  block requests a pixel
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse after CS deasserts at the end of a frame
- spi_clk  output  1  SPI clock, idle low (mode 0)
- spi_cs  output  1  chip select, active-low, idle high
- spi_di  output  1  serial data to the display
- spi_dc  output  1  0 = command byte, 1 = data byte

Behaviour:
- **Reset** (reset_n low at a clk edge), including mid-transaction:
  - Next cycle: spi_cs=1, spi_clk=0, spi_di=0, spi_dc=0, busy=0, done=0, pixel_ready=0, win_ready=1.
  - All counters cleared; no partial byte is completed.
- **States:** IDLE, CS_SETUP, SHIFT, NEXT, PIX_WAIT, CS_HOLD.
- **IDLE:**
  - On win_valid & win_ready: latch the four coordinates, set busy=1, drive spi_cs=0, enter CS_SETUP.
  - If win_x_end < win_x_start, the latched x_end is forced to x_start. The y range is handled the same way.
- **CS_SETUP:** wait CLK_DIV cycles, then load the first byte and enter SHIFT.
- **Byte sequence (dc shown in parentheses):**
  - 0x2A(0), xs[15:8](1), xs[7:0](1), xe[15:8](1), xe[7:0](1)
  - 0x2B(0), ys[15:8](1), ys[7:0](1), ye[15:8](1), ye[7:0](1)
  - 0x2C(0)
  - Then N pixels, each as pix[15:8](1), pix[7:0](1), where N = (xe-xs+1)*(ye-ys+1).
- **SHIFT:**
  - spi_di and spi_dc are updated only while spi_clk is low: at byte load and on each falling edge. Bits go out MSB first.
  - spi_clk toggles every CLK_DIV cycles: low for CLK_DIV, high for CLK_DIV, 8 times per byte.
  - A byte therefore takes 16*CLK_DIV cycles, and spi_di is stable across each rising edge.
  - spi_dc is constant for the whole byte.
- **NEXT** (entered after the 8th falling edge; spi_clk low):
  - If more header bytes remain, load the next one on the same cycle, with no gap between bytes.
  - If a pixel high byte is due, enter PIX_WAIT.
  - If the low byte is done, advance the position counters.
  - If that was the final pixel, enter CS_HOLD.
- **PIX_WAIT:**
  - pixel_ready=1. A pixel is accepted on pixel_valid & pixel_ready; the block loads pix[15:8] to SHIFT next cycle and buffers pix[7:0].
  - While pixel_valid=0: stall with spi_clk low, spi_cs low, spi_di/dc held.
  - pixel_ready is 0 in every other state. Exactly N pixels are accepted per window.
- **Position counters:**
  - x runs xs..xe. On wrap, x returns to xs and y increments.
  - The frame ends after the pixel at (xe, ye).
  - Counters are WIDTH wide. The range is inclusive, so xs==xe gives 1 column.
- **CS_HOLD:**
  - Wait CLK_DIV cycles with spi_clk low, then set spi_cs=1.
  - Also set busy=0, pulse done for one cycle, and return to IDLE.
  - A new win_valid may be accepted on the cycle after done; CS then stays high for at least 1 cycle.
- **Other rules:**
  - win_valid asserted while busy is ignored (win_ready=0).
  - pixel_valid asserted outside PIX_WAIT is ignored.

Test Plan:
- **Basic frame:** CLK_DIV=2, window (0,0)-(1,0), pixels 0xABCD, 0x1234.
  - Decoded bytes, captured on rising spi_clk: 2A 00 00 00 01 2B 00 00 00 00 2C AB CD 12 34.
  - dc pattern: 0 1111 0 1111 0 1111.
  - Exactly 15*8 rising edges; done pulses once.
- **Timing:** CLK_DIV=2.
  - First spi_clk rise occurs 2 cycles after spi_cs falls.
  - Each half-period is 2 cycles.
  - spi_cs rises 2 cycles after the last falling edge.
  - spi_di never changes while spi_clk is high.
- **Stall:** hold pixel_valid low for 37 cycles before the second pixel.
  - spi_clk stays low and spi_cs stays low throughout the stall.
  - The byte stream is identical to the basic-frame test; no extra edges.
- **Wrap and large coordinates:** window (0x0123,0x0040)-(0x0124,0x0041), 4 pixels.
  - Header bytes: 01 23 01 24 / 00 40 00 41.
  - Exactly 4 pixels accepted; the 5th pixel_valid is not accepted.
- **Reversed window:** x_start=5, x_end=3.
  - Sent xe equals 5.
  - One pixel per row.
- **Reset mid-pixel:** assert reset_n=0 during the 4th bit of a pixel byte.
  - Next cycle: spi_cs=1, spi_clk=0, busy=0.
  - A new window afterwards produces a clean, complete sequence.

Source files
------------

// File: rtl/spi_display_host.sv
// Write-only 4-wire SPI host for ILI9340-style displays: frames a pixel window
// (0x2A / 0x2B / 0x2C header) and streams RGB565 pixels, mode 0, MSB first.
module spi_display_host #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] win_x_start,
    input  logic [WIDTH-1:0] win_y_start,
    input  logic [WIDTH-1:0] win_x_end,
    input  logic [WIDTH-1:0] win_y_end,
    input  logic             win_valid,
    output logic             win_ready,
    input  logic [15:0]      pixel_data,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic             busy,
    output logic             done,
    output logic             spi_clk,
    output logic             spi_cs,
    output logic             spi_di,
    output logic             spi_dc
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0] HDR_LAST = 4'd10;
    localparam int EXT_W = (WIDTH > 16) ? WIDTH : 16;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        NEXT,
        PIX_WAIT,
        CS_HOLD
    } state_t;

    typedef enum logic [1:0] {
        K_HDR,
        K_PIX_HI,
        K_PIX_LO
    } kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       hdr_idx_q, hdr_idx_d;
    logic             spi_clk_q, spi_clk_d;
    logic             spi_cs_q, spi_cs_d;
    logic             spi_di_q, spi_di_d;
    logic             spi_dc_q, spi_dc_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] xe_q, xe_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] ye_q, ye_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       pix_lo_q, pix_lo_d;

    logic             div_hit;
    logic             last_pix;
    logic [8:0]       nxt_hdr;

    // Coordinates always go out as 16 bits; wider fields are truncated.
    function automatic logic [15:0] to16(input logic [WIDTH-1:0] v);
        logic [EXT_W-1:0] ext;
        ext = '0;
        ext[WIDTH-1:0] = v;
        return ext[15:0];
    endfunction

    // Header byte at position idx, returned as {dc, byte}.
    function automatic logic [8:0] hdr_byte(input logic [3:0] idx,
                                            input logic [15:0] xs, input logic [15:0] xe,
                                            input logic [15:0] ys, input logic [15:0] ye);
        logic [8:0] b;
        case (idx)
            4'd0:    b = {1'b0, 8'h2A};
            4'd1:    b = {1'b1, xs[15:8]};
            4'd2:    b = {1'b1, xs[7:0]};
            4'd3:    b = {1'b1, xe[15:8]};
            4'd4:    b = {1'b1, xe[7:0]};
            4'd5:    b = {1'b0, 8'h2B};
            4'd6:    b = {1'b1, ys[15:8]};
            4'd7:    b = {1'b1, ys[7:0]};
            4'd8:    b = {1'b1, ye[15:8]};
            4'd9:    b = {1'b1, ye[7:0]};
            default: b = {1'b0, 8'h2C};
        endcase
        return b;
    endfunction

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        hdr_idx_d = hdr_idx_q;
        spi_clk_d = spi_clk_q;
        spi_cs_d  = spi_cs_q;
        spi_di_d  = spi_di_q;
        spi_dc_d  = spi_dc_q;
        done_d    = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        xs_d      = xs_q;
        xe_d      = xe_q;
        ys_d      = ys_q;
        ye_d      = ye_q;
        sh_d      = sh_q;
        pix_lo_d  = pix_lo_q;

        div_hit  = (div_cnt_q == DIV_LAST);
        last_pix = (x_q == xe_q) && (y_q == ye_q);
        nxt_hdr  = hdr_byte(hdr_idx_q + 4'd1, to16(xs_q), to16(xe_q), to16(ys_q), to16(ye_q));

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    xs_d      = win_x_start;
                    ys_d      = win_y_start;
                    xe_d      = (win_x_end < win_x_start) ? win_x_start : win_x_end;
                    ye_d      = (win_y_end < win_y_start) ? win_y_start : win_y_end;
                    x_d       = win_x_start;
                    y_d       = win_y_start;
                    hdr_idx_d = 4'd0;
                    kind_d    = K_HDR;
                    // The 0x2A command bit is presented with CS so the setup
                    // interval doubles as the low half of its first bit.
                    sh_d      = 8'h2A;
                    spi_di_d  = 1'b0;
                    spi_dc_d  = 1'b0;
                    bit_cnt_d = 3'd0;
                    div_cnt_d = '0;
                    spi_clk_d = 1'b0;
                    spi_cs_d  = 1'b0;
                    state_d   = CS_SETUP;
                end
            end

            CS_SETUP: begin
                if (div_hit) begin
                    div_cnt_d = '0;
                    spi_clk_d = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            SHIFT, NEXT: begin
                if (!div_hit) begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end else begin
                    div_cnt_d = '0;
                    if (!spi_clk_q) begin
                        spi_clk_d = 1'b1;
                        state_d   = SHIFT;
                    end else begin
                        spi_clk_d = 1'b0;
                        if (bit_cnt_q != 3'd7) begin
                            sh_d      = {sh_q[6:0], 1'b0};
                            spi_di_d  = sh_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end else begin
                            // Eighth falling edge: the following byte starts now.
                            bit_cnt_d = 3'd0;
                            case (kind_q)
                                K_HDR: begin
                                    if (hdr_idx_q != HDR_LAST) begin
                                        hdr_idx_d = hdr_idx_q + 4'd1;
                                        sh_d      = nxt_hdr[7:0];
                                        spi_di_d  = nxt_hdr[7];
                                        spi_dc_d  = nxt_hdr[8];
                                        state_d   = NEXT;
                                    end else begin
                                        state_d = PIX_WAIT;
                                    end
                                end
                                K_PIX_HI: begin
                                    kind_d   = K_PIX_LO;
                                    sh_d     = pix_lo_q;
                                    spi_di_d = pix_lo_q[7];
                                    spi_dc_d = 1'b1;
                                    state_d  = NEXT;
                                end
                                default: begin
                                    if (last_pix) begin
                                        state_d = CS_HOLD;
                                    end else begin
                                        if (x_q == xe_q) begin
                                            x_d = xs_q;
                                            y_d = y_q + WIDTH'(1);
                                        end else begin
                                            x_d = x_q + WIDTH'(1);
                                        end
                                        state_d = PIX_WAIT;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end

            PIX_WAIT: begin
                if (pixel_valid) begin
                    sh_d      = pixel_data[15:8];
                    pix_lo_d  = pixel_data[7:0];
                    spi_di_d  = pixel_data[15];
                    spi_dc_d  = 1'b1;
                    kind_d    = K_PIX_HI;
                    bit_cnt_d = 3'd0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            CS_HOLD: begin
                if (div_hit) begin
                    div_cnt_d = '0;
                    spi_cs_d  = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            kind_q    <= K_HDR;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            hdr_idx_q <= '0;
            spi_clk_q <= 1'b0;
            spi_cs_q  <= 1'b1;
            spi_di_q  <= 1'b0;
            spi_dc_q  <= 1'b0;
            done_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            hdr_idx_q <= hdr_idx_d;
            spi_clk_q <= spi_clk_d;
            spi_cs_q  <= spi_cs_d;
            spi_di_q  <= spi_di_d;
            spi_dc_q  <= spi_dc_d;
            done_q    <= done_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    // Window bounds and byte buffers are only read after being loaded.
    always_ff @(posedge clk) begin
        xs_q     <= xs_d;
        xe_q     <= xe_d;
        ys_q     <= ys_d;
        ye_q     <= ye_d;
        sh_q     <= sh_d;
        pix_lo_q <= pix_lo_d;
    end

    assign win_ready   = (state_q == IDLE);
    assign pixel_ready = (state_q == PIX_WAIT);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign spi_clk     = spi_clk_q;
    assign spi_cs      = spi_cs_q;
    assign spi_di      = spi_di_q;
    assign spi_dc      = spi_dc_q;

endmodule

// File: tb/tb_spi_display_host.sv
// Self-checking bench for spi_display_host: decodes the SPI bus into {dc,byte}
// records and compares them against a queue of bytes predicted from the stimulus.
`timescale 1ns/1ps
module tb_spi_display_host;

    localparam int WIDTH   = 16;
    localparam int CLK_DIV = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] win_x_start = '0, win_y_start = '0, win_x_end = '0, win_y_end = '0;
    logic             win_valid = 1'b0;
    logic             win_ready;
    logic [15:0]      pixel_data = '0;
    logic             pixel_valid = 1'b0;
    logic             pixel_ready, busy, done;
    logic             spi_clk, spi_cs, spi_di, spi_dc;

    always #5 clk = ~clk;

    spi_display_host #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset_n(reset_n),
        .win_x_start(win_x_start), .win_y_start(win_y_start),
        .win_x_end(win_x_end), .win_y_end(win_y_end),
        .win_valid(win_valid), .win_ready(win_ready),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .busy(busy), .done(done),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_di(spi_di), .spi_dc(spi_dc)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];

    // Bus monitor state, sampled on the falling clk edge.
    int   cyc = 0;
    logic prev_clk = 1'b0, prev_cs = 1'b1, prev_di = 1'b0;
    int   bitn = 0;
    logic [7:0] acc = '0;
    logic byte_dc = 1'b0;
    int   rises = 0, di_err = 0, dc_err = 0, high_err = 0, low_err = 0, partial = 0;
    int   cs_fall_cyc = 0, cs_rise_cyc = 0, first_rise_cyc = -1, last_edge_cyc = 0, last_fall_cyc = 0;
    bit   ready_seen = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            bitn = 0; prev_clk = 1'b0; prev_cs = 1'b1; prev_di = 1'b0;
        end else begin
            if (prev_cs && !spi_cs) begin
                cs_fall_cyc = cyc; last_edge_cyc = cyc; first_rise_cyc = -1;
                rises = 0; di_err = 0; dc_err = 0; high_err = 0; low_err = 0; ready_seen = 1'b0;
            end
            if (!prev_cs && spi_cs) begin
                cs_rise_cyc = cyc;
                if (bitn != 0) partial++;
                bitn = 0;
            end
            if (pixel_ready) ready_seen = 1'b1;
            if (spi_clk && !prev_clk) begin
                rises++;
                if (first_rise_cyc < 0) first_rise_cyc = cyc;
                if (!ready_seen && (cyc - last_edge_cyc) != CLK_DIV) low_err++;
                last_edge_cyc = cyc;
                ready_seen = 1'b0;
                acc = {acc[6:0], spi_di};
                if (bitn == 0) byte_dc = spi_dc;
                else if (spi_dc !== byte_dc) dc_err++;
                bitn++;
                if (bitn == 8) begin
                    rx_q.push_back({byte_dc, acc});
                    bitn = 0;
                end
            end
            if (!spi_clk && prev_clk) begin
                if ((cyc - last_edge_cyc) != CLK_DIV) high_err++;
                last_edge_cyc = cyc;
                last_fall_cyc = cyc;
            end
            if (spi_clk && prev_clk && (spi_di !== prev_di)) di_err++;
            prev_clk = spi_clk; prev_cs = spi_cs; prev_di = spi_di;
        end
    end

    // Expected header for a window, with reversed ranges clamped to the start.
    function automatic void push_header(input logic [15:0] xs, input logic [15:0] ys,
                                        input logic [15:0] xe, input logic [15:0] ye);
        logic [15:0] xe_e, ye_e;
        xe_e = (xe < xs) ? xs : xe;
        ye_e = (ye < ys) ? ys : ye;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, xs[15:8]});   exp_q.push_back({1'b1, xs[7:0]});
        exp_q.push_back({1'b1, xe_e[15:8]}); exp_q.push_back({1'b1, xe_e[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, ys[15:8]});   exp_q.push_back({1'b1, ys[7:0]});
        exp_q.push_back({1'b1, ye_e[15:8]}); exp_q.push_back({1'b1, ye_e[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
    endfunction

    task automatic send_window(input logic [15:0] xs, input logic [15:0] ys,
                               input logic [15:0] xe, input logic [15:0] ye, output bit ok);
        ok = 1'b0;
        push_header(xs, ys, xe, ye);
        win_x_start = xs; win_y_start = ys; win_x_end = xe; win_y_end = ye;
        win_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (win_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        win_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic [15:0] p, output bit ok);
        ok = 1'b0;
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
        pixel_data = p;
        pixel_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (pixel_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    task automatic wait_done(output int ndone);
        ndone = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                break;
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (spi_cs !== 1'b1)      begin errors++; $display("FAIL reset_cs: got %b want 1", spi_cs); end
        checks++; if (spi_clk !== 1'b0)     begin errors++; $display("FAIL reset_clk: got %b want 0", spi_clk); end
        checks++; if (spi_di !== 1'b0)      begin errors++; $display("FAIL reset_di: got %b want 0", spi_di); end
        checks++; if (spi_dc !== 1'b0)      begin errors++; $display("FAIL reset_dc: got %b want 0", spi_dc); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (pixel_ready !== 1'b0) begin errors++; $display("FAIL reset_pixel_ready: got %b want 0", pixel_ready); end
        checks++; if (win_ready !== 1'b1)   begin errors++; $display("FAIL reset_win_ready: got %b want 1", win_ready); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        bit ok_w, ok1, ok2;
        int nd;
        clear_queues();
        send_window(16'd0, 16'd0, 16'd1, 16'd0, ok_w);
        send_pixel(16'hABCD, ok1);
        send_pixel(16'h1234, ok2);
        wait_done(nd);
        checks++; if (!(ok_w && ok1 && ok2)) begin errors++; $display("FAIL basic_handshake: got win=%0b p1=%0b p2=%0b want 1 1 1", ok_w, ok1, ok2); end
        checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_byte_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte[%0d]: got dc=%b %h want dc=%b %h", i, rx_q[i][8], rx_q[i][7:0], exp_q[i][8], exp_q[i][7:0]); end
        end
        checks++; if (rises !== 15 * 8) begin errors++; $display("FAIL basic_rises: got %0d want %0d", rises, 15 * 8); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", nd); end
        checks++; if (first_rise_cyc - cs_fall_cyc !== CLK_DIV) begin errors++; $display("FAIL timing_cs_setup: got %0d want %0d", first_rise_cyc - cs_fall_cyc, CLK_DIV); end
        checks++; if (cs_rise_cyc - last_fall_cyc !== CLK_DIV) begin errors++; $display("FAIL timing_cs_hold: got %0d want %0d", cs_rise_cyc - last_fall_cyc, CLK_DIV); end
        checks++; if (high_err !== 0) begin errors++; $display("FAIL timing_high_half: got %0d bad halves want 0", high_err); end
        checks++; if (low_err !== 0) begin errors++; $display("FAIL timing_low_half: got %0d bad halves want 0", low_err); end
        checks++; if (di_err !== 0) begin errors++; $display("FAIL timing_di_while_high: got %0d changes want 0", di_err); end
        checks++; if (dc_err !== 0) begin errors++; $display("FAIL dc_within_byte: got %0d changes want 0", dc_err); end
        checks++; if (partial !== 0) begin errors++; $display("FAIL partial_bytes: got %0d want 0", partial); end
    endtask

    task automatic test_stall();
        bit ok_w, ok1, ok2;
        int nd, stall_viol, waited;
        clear_queues();
        stall_viol = 0;
        send_window(16'd0, 16'd0, 16'd1, 16'd0, ok_w);
        send_pixel(16'hABCD, ok1);
        waited = 0;
        while (!pixel_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (pixel_ready !== 1'b1) begin errors++; $display("FAIL stall_reach_wait: got ready=%b want 1", pixel_ready); end
        repeat (37) begin
            @(negedge clk);
            if (spi_clk !== 1'b0 || spi_cs !== 1'b0) stall_viol++;
        end
        send_pixel(16'h1234, ok2);
        wait_done(nd);
        checks++; if (!(ok_w && ok1 && ok2)) begin errors++; $display("FAIL stall_handshake: got win=%0b p1=%0b p2=%0b want 1 1 1", ok_w, ok1, ok2); end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_bus_idle: got %0d bad cycles want 0", stall_viol); end
        checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_byte_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (rises !== 15 * 8) begin errors++; $display("FAIL stall_rises: got %0d want %0d", rises, 15 * 8); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL stall_done_pulses: got %0d want 1", nd); end
        checks++; if (di_err !== 0) begin errors++; $display("FAIL stall_di_while_high: got %0d want 0", di_err); end
    endtask

    task automatic test_wrap_large();
        bit ok_w;
        bit ok[4];
        int nd, extra, accepted;
        logic [15:0] pix[4];
        clear_queues();
        pix[0] = 16'h0F0F; pix[1] = 16'hF0F0; pix[2] = 16'h5A5A; pix[3] = 16'hC3C3;
        send_window(16'h0123, 16'h0040, 16'h0124, 16'h0041, ok_w);
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            send_pixel(pix[i], ok[i]);
            if (ok[i]) accepted++;
        end
        pixel_data = 16'hDEAD;
        pixel_valid = 1'b1;
        extra = 0;
        nd = 0;
        for (int i = 0; i < 3000 && nd == 0; i++) begin
            if (pixel_ready) extra++;
            @(negedge clk);
            if (done) nd++;
        end
        repeat (10) begin
            @(negedge clk);
            if (pixel_ready) extra++;
            if (done) nd++;
        end
        pixel_valid = 1'b0;
        checks++; if (ok_w !== 1'b1) begin errors++; $display("FAIL wrap_window_accept: got %0b want 1", ok_w); end
        checks++; if (accepted !== 4) begin errors++; $display("FAIL wrap_pixels_accepted: got %0d want 4", accepted); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL wrap_fifth_pixel: got %0d extra ready cycles want 0", extra); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL wrap_done_pulses: got %0d want 1", nd); end
        checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_byte_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reversed();
        bit ok_w, ok1, ok2;
        int nd;
        clear_queues();
        send_window(16'd5, 16'd0, 16'd3, 16'd1, ok_w);
        send_pixel(16'h8001, ok1);
        send_pixel(16'h7FFE, ok2);
        wait_done(nd);
        checks++; if (!(ok_w && ok1 && ok2)) begin errors++; $display("FAIL rev_handshake: got win=%0b p1=%0b p2=%0b want 1 1 1", ok_w, ok1, ok2); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL rev_done_pulses: got %0d want 1", nd); end
        checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL rev_byte_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rev_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_pixel();
        bit ok_w, ok1, ok2;
        int nd, waited;
        clear_queues();
        send_window(16'd0, 16'd0, 16'd1, 16'd0, ok_w);
        send_pixel(16'hABCD, ok1);
        waited = 0;
        while (bitn != 3 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (bitn !== 3) begin errors++; $display("FAIL rstmid_reach_bit: got %0d want 3", bitn); end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (spi_cs !== 1'b1)  begin errors++; $display("FAIL rstmid_cs: got %b want 1", spi_cs); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rstmid_clk: got %b want 0", spi_clk); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (pixel_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pixel_ready: got %b want 0", pixel_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_queues();
        send_window(16'd0, 16'd0, 16'd1, 16'd0, ok_w);
        send_pixel(16'hABCD, ok1);
        send_pixel(16'h1234, ok2);
        wait_done(nd);
        checks++; if (!(ok_w && ok1 && ok2)) begin errors++; $display("FAIL rstmid_handshake: got win=%0b p1=%0b p2=%0b want 1 1 1", ok_w, ok1, ok2); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL rstmid_done_pulses: got %0d want 1", nd); end
        checks++; if (rises !== 15 * 8) begin errors++; $display("FAIL rstmid_rises: got %0d want %0d", rises, 15 * 8); end
        checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_byte_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_wrap_large();
        test_reversed();
        test_reset_mid_pixel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
